bullet_tile_hit: RTL and testbench
==================================

// Module: bullet_tile_hit
// PURPOSE
//  Bullet-vs-map hit resolver; the writer/client end of the tile map's rd/wr ports.
//  Takes one bullet pixel position per request and converts it to tile coords.
//  Reads the tile through the map read port (1-cycle latency), clears it via the write port if brick.
//  Reports hit/tile type to the bullet logic. Sits between the bullet engine and the map store.
// PARAMETERS
//  MAP_W      25  map width in tiles
//  MAP_H      18  map height in tiles
//  TILE_SHIFT 3   log2 of tile size in pixels (8x8 tiles)
//  Y_OFFSET   6   status-bar rows above the playfield; py < Y_OFFSET is off-map
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous reset, active-high
//  req_valid    in   1  hit-check request
//  req_ready    out  1  high only in IDLE; request accepted on clk edge with valid&ready
//  req_px       in   8  bullet x, pixels
//  req_py       in   8  bullet y, pixels (includes status bar)
//  map_rd_x     out  5  tile x to the map read port
//  map_rd_y     out  5  tile y to the map read port
//  map_rd_tile  in   2  map read data: 0 empty, 1 brick, 2 iron; valid 1 cycle after address
//  map_wr_en    out  1  one-cycle write strobe to the map
//  map_wr_x     out  5  tile x to write
//  map_wr_y     out  5  tile y to write
//  map_wr_tile  out  2  always 2'd0 (clear)
//  rsp_valid    out  1  one-cycle response pulse; no back-pressure
//  rsp_hit      out  1  1 if the tile is non-empty or off-map
//  rsp_tile     out  2  resolved tile type (2 for off-map)
//  brick_count  out  8  bricks destroyed (only with HIT_COUNT_EN)
// BEHAVIOUR
//  - Reset: state IDLE; all registered outputs 0; req_ready=1. Async: a pending write strobe drops immediately.
//  - Accept: tx = px>>TILE_SHIFT; ty = (py-Y_OFFSET)>>TILE_SHIFT, computed only when py>=Y_OFFSET (no wrap).
//  - Off-map: py<Y_OFFSET, tx>=MAP_W or ty>=MAP_H.
//    Accept edge goes to RESP; map_rd_x/y unchanged; tile=2, hit=1; no write.
//  - FSM: IDLE -> ADDR -> READ -> WRITE -> RESP -> IDLE.
//  - IDLE->ADDR on accept; map_rd_x/y and map_wr_x/y registered from tx/ty.
//  - ADDR->READ unconditionally; the map samples the address on this edge.
//  - READ->WRITE: capture map_rd_tile into tile_q.
//    Set map_wr_en = (map_rd_tile==1) for exactly the WRITE cycle.
//  - WRITE->RESP: map_wr_en cleared; rsp_valid=1, rsp_hit=(tile_q!=0), rsp_tile=tile_q for one cycle.
//  - RESP->IDLE: rsp_valid cleared; rsp_hit/rsp_tile hold until the next response.
//  - Latency: rsp_valid high in the 4th cycle after the accept edge; off-map case in the 1st.
//  - req_valid while not IDLE: ignored; the requester holds its request.
//  - Back-to-back throughput: one request per 5 cycles (2 for off-map).
//  - Never writes non-brick tiles. map_rd_x/y hold their last value outside ADDR/READ.
//  - Rst mid-operation: the request is dropped; no rsp_valid and no write are emitted for it.
// CONFIGURATION
//  HIT_COUNT_EN defined:
//    brick_count port present, reset 0.
//    +1 on each cycle map_wr_en=1; saturates at 255.
//  HIT_COUNT_EN undefined: brick_count port and counter absent; all other behaviour identical.
// TESTING
//  1 reset: rst=1 -> req_ready=1, rsp_valid=0, map_wr_en=0, rsp_hit=0, map_rd_x/y=0.
//  2 brick: px=36,py=30, model returns 1 at (4,3) -> rd (4,3); wr_en one cycle, wr (4,3,0);
//    rsp_valid 4th cycle after accept, hit=1, tile=1.
//  3 iron: px=100,py=70 -> rd (12,8); model 2 -> no wr_en, rsp hit=1 tile=2.
//    Empty px=16,py=22 (2,2) -> hit=0, tile=0.
//  4 edges: px=199,py=149 -> (24,17) read.
//    px=200 or py=5 or py=150 -> rsp next cycle, hit=1, tile=2, no read/write.
//  5 busy/reset: req_valid held for 2 requests -> second accepted only after RESP.
//    rst asserted during WRITE -> wr_en low at once, IDLE, no rsp.
//  6 HIT_COUNT_EN: 3 brick hits -> brick_count=3; preload 255 + brick -> stays 255.

Source files
------------

// File: rtl/bullet_tile_hit.sv
// -----------------------------------------------------------------------------
// bullet_tile_hit
//
// Resolves whether a bullet at a pixel position hits something on the tile map.
// The module sits between the bullet engine, which requests checks, and the map
// store, which it drives through a read port and a write port.
//
// Flow for one request:
//   - The pixel position is converted to tile coordinates.
//   - Positions outside the playfield answer straight away as "iron" (hit, tile
//     2). They do not touch the map.
//   - Otherwise the tile is read with one cycle of read latency. If it is a
//     brick it is cleared with a single write strobe. Then a one-cycle response
//     pulse reports the tile type.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-high
//   req_valid    hit-check request
//   req_ready    high only while idle; a request is taken on valid & ready
//   req_px       bullet x in pixels
//   req_py       bullet y in pixels, status bar included
//   map_rd_x/y   tile address to the map read port (holds its last value)
//   map_rd_tile  map read data, valid one cycle after the address
//                (0 empty, 1 brick, 2 iron)
//   map_wr_en    one-cycle write strobe to the map
//   map_wr_x/y   tile address to write
//   map_wr_tile  write data, always 0 (clear the tile)
//   rsp_valid    one-cycle response pulse, no back-pressure
//   rsp_hit      tile non-empty or position off-map (holds until next rsp)
//   rsp_tile     resolved tile type, 2 for off-map (holds until next rsp)
//   brick_count  saturating count of destroyed bricks
//                (port exists only when HIT_COUNT_EN is defined)
//
// Build option
//   HIT_COUNT_EN : adds brick_count. Without it the port and the counter are
//                  absent, and all other behaviour is the same.
// -----------------------------------------------------------------------------
module bullet_tile_hit #(
    parameter int MAP_W      = 25,
    parameter int MAP_H      = 18,
    parameter int TILE_SHIFT = 3,
    parameter int Y_OFFSET   = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_px,
    input  logic [7:0] req_py,
    output logic [4:0] map_rd_x,
    output logic [4:0] map_rd_y,
    input  logic [1:0] map_rd_tile,
    output logic       map_wr_en,
    output logic [4:0] map_wr_x,
    output logic [4:0] map_wr_y,
    output logic [1:0] map_wr_tile,
    output logic       rsp_valid,
    output logic       rsp_hit,
    output logic [1:0] rsp_tile
`ifdef HIT_COUNT_EN
    ,
    output logic [7:0] brick_count
`endif
);

    localparam logic [1:0] TILE_EMPTY = 2'd0;
    localparam logic [1:0] TILE_BRICK = 2'd1;
    localparam logic [1:0] TILE_IRON  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t     state_reg;
    logic [1:0] tile_q_reg;

    // ------------------------------------------------------------------
    // Pixel -> tile conversion.
    // The vertical subtraction is only meaningful when py >= Y_OFFSET. The
    // status-bar rows are rejected before the result is used, so the
    // wrapped value is never used.
    // ------------------------------------------------------------------
    logic [7:0] tx_full;
    logic [7:0] py_rel;
    logic [7:0] ty_full;
    logic       in_status_bar;
    logic       off_map;
    logic       accept;

    always_comb begin
        tx_full       = req_px >> TILE_SHIFT;
        py_rel        = req_py - 8'(Y_OFFSET);
        ty_full       = py_rel >> TILE_SHIFT;
        in_status_bar = (req_py < 8'(Y_OFFSET));
        off_map       = in_status_bar
                        || (tx_full >= 8'(MAP_W))
                        || (ty_full >= 8'(MAP_H));
    end

    assign req_ready   = (state_reg == S_IDLE);
    assign accept      = req_valid && req_ready;
    assign map_wr_tile = TILE_EMPTY;

    // ------------------------------------------------------------------
    // Control FSM with registered outputs.
    // rsp_valid and map_wr_en default low every cycle. Only the state that
    // owns each strobe raises it, so each is a single-cycle pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            tile_q_reg <= TILE_EMPTY;
            map_rd_x   <= '0;
            map_rd_y   <= '0;
            map_wr_x   <= '0;
            map_wr_y   <= '0;
            map_wr_en  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_hit    <= 1'b0;
            rsp_tile   <= TILE_EMPTY;
        end else begin
            map_wr_en <= 1'b0;
            rsp_valid <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        if (off_map) begin
                            // Answer at once as solid iron. The map ports
                            // keep their previous addresses.
                            state_reg <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_hit   <= 1'b1;
                            rsp_tile  <= TILE_IRON;
                        end else begin
                            state_reg <= S_ADDR;
                            map_rd_x  <= tx_full[4:0];
                            map_rd_y  <= ty_full[4:0];
                            map_wr_x  <= tx_full[4:0];
                            map_wr_y  <= ty_full[4:0];
                        end
                    end
                end

                // The address is stable during this cycle. The map
                // samples it on the edge that leaves this state.
                S_ADDR: begin
                    state_reg <= S_READ;
                end

                // Read data is valid now. Only bricks are destroyed.
                S_READ: begin
                    state_reg  <= S_WRITE;
                    tile_q_reg <= map_rd_tile;
                    map_wr_en  <= (map_rd_tile == TILE_BRICK);
                end

                S_WRITE: begin
                    state_reg <= S_RESP;
                    rsp_valid <= 1'b1;
                    rsp_hit   <= (tile_q_reg != TILE_EMPTY);
                    rsp_tile  <= tile_q_reg;
                end

                // rsp_hit and rsp_tile keep their values for the requester.
                S_RESP: begin
                    state_reg <= S_IDLE;
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

`ifdef HIT_COUNT_EN
    // ------------------------------------------------------------------
    // Destroyed-brick counter. Each write strobe is one brick. The count
    // sticks at 255 and does not wrap.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            brick_count <= '0;
        end else if (map_wr_en && (brick_count != 8'hFF)) begin
            brick_count <= brick_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bullet_tile_hit.sv
module tb_bullet_tile_hit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_px = 8'd0;
    logic [7:0] req_py = 8'd0;
    logic [4:0] map_rd_x;
    logic [4:0] map_rd_y;
    logic [1:0] map_rd_tile;
    logic       map_wr_en;
    logic [4:0] map_wr_x;
    logic [4:0] map_wr_y;
    logic [1:0] map_wr_tile;
    logic       rsp_valid;
    logic       rsp_hit;
    logic [1:0] rsp_tile;
`ifdef HIT_COUNT_EN
    logic [7:0] brick_count;
`endif

    int checks = 0;
    int failures = 0;
    int exp_bricks = 0;

    always #5 clk = ~clk;

    bullet_tile_hit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_px     (req_px),
        .req_py     (req_py),
        .map_rd_x   (map_rd_x),
        .map_rd_y   (map_rd_y),
        .map_rd_tile(map_rd_tile),
        .map_wr_en  (map_wr_en),
        .map_wr_x   (map_wr_x),
        .map_wr_y   (map_wr_y),
        .map_wr_tile(map_wr_tile),
        .rsp_valid  (rsp_valid),
        .rsp_hit    (rsp_hit),
        .rsp_tile   (rsp_tile)
`ifdef HIT_COUNT_EN
        ,
        .brick_count(brick_count)
`endif
    );

    // Map model: registered read, write on strobe, bench preload port.
    logic [1:0] mem [0:17][0:24];
    logic       clr = 1'b1;
    logic       pl_en = 1'b0;
    logic [4:0] pl_x = 5'd0;
    logic [4:0] pl_y = 5'd0;
    logic [1:0] pl_v = 2'd0;
    logic [1:0] rd_data = 2'd0;

    assign map_rd_tile = rd_data;

    always @(posedge clk) begin
        rd_data <= mem[map_rd_y][map_rd_x];
        if (clr) begin
            for (int y = 0; y < 18; y++)
                for (int x = 0; x < 25; x++)
                    mem[y][x] <= 2'd0;
        end else begin
            if (pl_en) mem[pl_y][pl_x] <= pl_v;
            if (map_wr_en) mem[map_wr_y][map_wr_x] <= map_wr_tile;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic set_tile(input int x, input int y, input int v);
        pl_en = 1'b1;
        pl_x  = 5'(x);
        pl_y  = 5'(y);
        pl_v  = 2'(v);
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // One request from idle. lat counts edges from and including the accept edge.
    task automatic run_req(input string tag, input int px, input int py,
                           input int exp_lat, input int exp_hit, input int exp_tile,
                           input int exp_wr, input int exp_x, input int exp_y);
        int k;
        int waitc;
        int wr_seen;
        waitc = 0;
        wr_seen = 0;
        while (!req_ready && waitc < 20) begin
            @(posedge clk); #1;
            waitc++;
        end
        chk({tag, "_ready"}, int'(req_ready), 1);
        req_valid = 1'b1;
        req_px = 8'(px);
        req_py = 8'(py);
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = 1;
        if (map_wr_en) begin
            wr_seen++;
            chk({tag, "_wr_x"}, int'(map_wr_x), exp_x);
            chk({tag, "_wr_y"}, int'(map_wr_y), exp_y);
        end
        while (!rsp_valid && k < 10) begin
            @(posedge clk); #1;
            k++;
            if (map_wr_en) begin
                wr_seen++;
                chk({tag, "_wr_x"}, int'(map_wr_x), exp_x);
                chk({tag, "_wr_y"}, int'(map_wr_y), exp_y);
                chk({tag, "_wr_tile"}, int'(map_wr_tile), 0);
            end
        end
        chk({tag, "_lat"}, k, exp_lat);
        chk({tag, "_hit"}, int'(rsp_hit), exp_hit);
        chk({tag, "_tile"}, int'(rsp_tile), exp_tile);
        chk({tag, "_wr_cnt"}, wr_seen, exp_wr);
        chk({tag, "_rd_x"}, int'(map_rd_x), exp_x);
        chk({tag, "_rd_y"}, int'(map_rd_y), exp_y);
        exp_bricks += exp_wr;
        $display("req %s px=%0d py=%0d lat=%0d hit=%0d tile=%0d wr=%0d",
                 tag, px, py, k, rsp_hit, rsp_tile, wr_seen);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, int'(rsp_valid), 0);
    endtask

    initial begin
        int k;
        int seen;

        // Reset and map preload
        @(posedge clk); #1;
        clr = 1'b0;
        set_tile(4, 3, 1);
        set_tile(12, 8, 2);
        set_tile(24, 17, 1);
        set_tile(6, 6, 1);
        set_tile(1, 1, 1);
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_wr_en", int'(map_wr_en), 0);
        chk("rst_rsp_hit", int'(rsp_hit), 0);
        chk("rst_rd_x", int'(map_rd_x), 0);
        chk("rst_rd_y", int'(map_rd_y), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Main function
        run_req("brick", 36, 30, 4, 1, 1, 1, 4, 3);
        chk("brick_cleared", int'(mem[3][4]), 0);
        run_req("rehit", 36, 30, 4, 0, 0, 0, 4, 3);
        run_req("iron", 100, 70, 4, 1, 2, 0, 12, 8);
        chk("iron_kept", int'(mem[8][12]), 2);
        run_req("empty", 16, 22, 4, 0, 0, 0, 2, 2);

        // Boundaries
        run_req("corner", 199, 149, 4, 1, 1, 1, 24, 17);
        run_req("off_x", 200, 30, 1, 1, 2, 0, 24, 17);
        run_req("off_bar", 0, 5, 1, 1, 2, 0, 24, 17);
        run_req("off_y", 0, 150, 1, 1, 2, 0, 24, 17);

        // Busy: request held across two transactions
        req_valid = 1'b1;
        req_px = 8'd48;
        req_py = 8'd54;
        @(posedge clk); #1;
        k = 1;
        chk("busy_ready_low", int'(req_ready), 0);
        req_px = 8'd100;
        req_py = 8'd70;
        while (!rsp_valid && k < 12) begin
            @(posedge clk); #1;
            k++;
        end
        chk("busy_a_lat", k, 4);
        chk("busy_a_tile", int'(rsp_tile), 1);
        chk("busy_a_rd_x", int'(map_rd_x), 6);
        exp_bricks += 1;
        @(posedge clk); #1;
        k++;
        chk("busy_idle_ready", int'(req_ready), 1);
        @(posedge clk); #1;
        k++;
        while (!rsp_valid && k < 16) begin
            @(posedge clk); #1;
            k++;
        end
        req_valid = 1'b0;
        chk("busy_b_lat", k, 9);
        chk("busy_b_tile", int'(rsp_tile), 2);
        chk("busy_b_rd_x", int'(map_rd_x), 12);
        chk("busy_b_rd_y", int'(map_rd_y), 8);
        $display("req busy pair second_rsp_edge=%0d", k);
        @(posedge clk); #1;

        // Reset during WRITE
        req_valid = 1'b1;
        req_px = 8'd8;
        req_py = 8'd14;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_wr_en_before", int'(map_wr_en), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_wr_en_drop", int'(map_wr_en), 0);
        chk("mid_ready", int'(req_ready), 1);
        chk("mid_rsp_valid", int'(rsp_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_bricks = 0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        chk("mid_no_rsp", seen, 0);
        chk("mid_tile_kept", int'(mem[1][1]), 1);
        $display("req reset_mid_write rsp_seen=%0d", seen);
        run_req("recover", 8, 14, 4, 1, 1, 1, 1, 1);

`ifdef HIT_COUNT_EN
        for (int i = 0; i < 2; i++) begin
            set_tile(10, 10, 1);
            run_req("count", 80, 86, 4, 1, 1, 1, 10, 10);
        end
        chk("count_3", int'(brick_count), exp_bricks);
        for (int i = 0; i < 253; i++) begin
            set_tile(10, 10, 1);
            run_req("sat", 80, 86, 4, 1, 1, 1, 10, 10);
        end
        chk("count_sat", int'(brick_count), 255);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
